fc_input_packer: RTL and testbench

//  Serial-to-parallel front end for the FC_16-based fully-connected layers.

---
 rtl/fc_input_packer_if.sv | 31 +++
 rtl/fc_input_packer.sv | 91 +++++++++
 tb/tb_fc_input_packer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_input_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : fc_input_packer_if
// Brief    : Stream-in / vector-out bundle for the FC layer input packer.
// Revision : 1.0 - initial release
// ============================================================================
interface fc_input_packer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 16
);
  logic [DATA_WIDTH-1:0]   s_data;
  logic                    s_valid;
  logic                    s_last;
  logic                    s_ready;
  logic [DATA_WIDTH*N-1:0] o_data;
  logic                    valid_out;
  logic                    frame_err;

  // Packer side: consumes the word stream, produces the assembled vector.
  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready, o_data, valid_out, frame_err
  );

  // Source/sink side: drives the stream, observes the vector.
  modport master (
    output s_data, s_valid, s_last,
    input  s_ready, o_data, valid_out, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/fc_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : fc_input_packer
// Brief    : Packs N stream words into one wide vector and issues it as a
//            single-cycle valid pulse with a programmable minimum spacing.
// Revision : 1.0 - initial release
// ============================================================================
module fc_input_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 16,
  parameter int MIN_GAP    = 0
) (
  input  wire logic         clk,
  input  wire logic         rst,
  fc_input_packer_if.slave  bus
);

  localparam int c_IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int c_GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_INIT = c_GAP_W'(MIN_GAP);

  logic [N-1:0][DATA_WIDTH-1:0] r_asm;
  logic [DATA_WIDTH*N-1:0]      r_o_data;
  logic [c_IDX_W-1:0]           r_idx;
  logic [c_GAP_W-1:0]           r_gap;
  logic                         r_asm_full;
  logic                         r_valid_out;
  logic                         r_frame_err;
  logic                         w_accept;
  logic                         w_issue;

  assign w_accept = bus.s_valid & ~r_asm_full;
  assign w_issue  = r_asm_full & (r_gap == '0);

  // The assembly buffer needs no reset: every slot is rewritten before
  // the vector can be issued.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_asm[r_idx] <= bus.s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_o_data    <= '0;
      r_valid_out <= 1'b0;
      r_frame_err <= 1'b0;
      r_idx       <= '0;
      r_asm_full  <= 1'b0;
      r_gap       <= '0;
    end else begin
      if (w_issue) begin
        r_o_data    <= r_asm;
        r_valid_out <= 1'b1;
        r_asm_full  <= 1'b0;
        r_gap       <= c_GAP_INIT;
      end else begin
        r_valid_out <= 1'b0;
        if (r_gap != '0) begin
          r_gap <= r_gap - c_GAP_W'(1);
        end
      end

      // Accept and issue are mutually exclusive: accept needs the buffer
      // empty, issue needs it full.
      if (w_accept) begin
        if (r_idx == c_LAST_IDX) begin
          r_asm_full <= 1'b1;
          r_idx      <= '0;
          if (!bus.s_last) begin
            r_frame_err <= 1'b1;
          end
        end else if (bus.s_last) begin
          // Short frame: the partial vector is abandoned.
          r_idx       <= '0;
          r_frame_err <= 1'b1;
        end else begin
          r_idx <= r_idx + c_IDX_W'(1);
        end
      end
    end
  end

  assign bus.s_ready   = ~r_asm_full;
  assign bus.o_data    = r_o_data;
  assign bus.valid_out = r_valid_out;
  assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_fc_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_input_packer
// Brief    : Directed, table-driven self-checking bench for fc_input_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_input_packer;

  localparam int DW = 32;
  localparam int NW = 16;
  localparam int VW = DW * NW;

  logic clk;
  logic rst;

  fc_input_packer_if #(.DATA_WIDTH(DW), .N(NW)) bus0 ();
  fc_input_packer_if #(.DATA_WIDTH(DW), .N(NW)) bus1 ();

  fc_input_packer #(.DATA_WIDTH(DW), .N(NW), .MIN_GAP(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  fc_input_packer #(.DATA_WIDTH(DW), .N(NW), .MIN_GAP(20)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- observers ----------------
  int          cyc = 0;
  int          pulses0 = 0;
  int          pulses1 = 0;
  int          rdy_low0 = 0;
  int          rdy_low1 = 0;
  int          stab_err = 0;
  bit          stab_en = 1'b0;
  logic [VW-1:0] last_data0;
  logic [VW-1:0] prev_o0;
  logic [VW-1:0] p1_data [2];
  int            p1_cyc  [2];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus0.valid_out === 1'b1) begin
      pulses0++;
      last_data0 = bus0.o_data;
    end
    if (bus1.valid_out === 1'b1) begin
      if (pulses1 < 2) begin
        p1_data[pulses1] = bus1.o_data;
        p1_cyc[pulses1]  = cyc;
      end
      pulses1++;
    end
    if (rst === 1'b1 && bus0.s_ready === 1'b0) rdy_low0++;
    if (rst === 1'b1 && bus1.s_ready === 1'b0) rdy_low1++;
    // o_data may only change together with a valid_out pulse
    if (!stab_en || bus0.valid_out === 1'b1) begin
      prev_o0 = bus0.o_data;
    end else if (bus0.o_data !== prev_o0) begin
      stab_err++;
      prev_o0 = bus0.o_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] mk_vec(input logic [31:0] base);
    logic [VW-1:0] v;
    for (int k = 0; k < NW; k++) v[k*DW +: DW] = base + 32'(k);
    return v;
  endfunction

  task automatic send_word0(input logic [31:0] d, input logic last);
    @(negedge clk);
    bus0.s_data  = d;
    bus0.s_last  = last;
    bus0.s_valid = 1'b1;
    for (int t = 0; t < 200 && bus0.s_ready !== 1'b1; t++) @(negedge clk);
    if (bus0.s_ready !== 1'b1) chk("s_ready0_timeout", VW'(bus0.s_ready), VW'(1));
    @(posedge clk);
    #1;
    bus0.s_valid = 1'b0;
    bus0.s_last  = 1'b0;
  endtask

  task automatic send_word1(input logic [31:0] d, input logic last);
    @(negedge clk);
    bus1.s_data  = d;
    bus1.s_last  = last;
    bus1.s_valid = 1'b1;
    for (int t = 0; t < 200 && bus1.s_ready !== 1'b1; t++) @(negedge clk);
    if (bus1.s_ready !== 1'b1) chk("s_ready1_timeout", VW'(bus1.s_ready), VW'(1));
    @(posedge clk);
    #1;
    bus1.s_valid = 1'b0;
    bus1.s_last  = 1'b0;
  endtask

  typedef struct {
    int unsigned nwords;
    logic [31:0] base;
    logic [31:0] bubbles;     // bit k: one idle cycle before word k
    bit          last;        // assert s_last on the final word
    int          exp_pulses;
    logic        exp_err;
  } vec_t;

  vec_t          vt [7];
  logic [VW-1:0] cur_exp;
  int            p0;
  int            r0;
  int            p1;
  int            r1;

  initial begin
    vt[0] = '{nwords:16, base:32'h4000_0000, bubbles:32'h0000_05A5, last:1'b1, exp_pulses:1, exp_err:1'b0};
    vt[1] = '{nwords:16, base:32'hC120_0000, bubbles:32'h0000_8F03, last:1'b1, exp_pulses:1, exp_err:1'b0};
    vt[2] = '{nwords:6,  base:32'h1111_0000, bubbles:32'h0000_0000, last:1'b1, exp_pulses:0, exp_err:1'b1};
    vt[3] = '{nwords:16, base:32'h7F7F_FFF0, bubbles:32'h0000_0030, last:1'b1, exp_pulses:1, exp_err:1'b1};
    vt[4] = '{nwords:16, base:32'hFFFF_FFF8, bubbles:32'h0000_0000, last:1'b0, exp_pulses:1, exp_err:1'b1};
    vt[5] = '{nwords:1,  base:32'h0000_0055, bubbles:32'h0000_0000, last:1'b1, exp_pulses:0, exp_err:1'b1};
    vt[6] = '{nwords:16, base:32'h8000_0000, bubbles:32'h0000_0001, last:1'b1, exp_pulses:1, exp_err:1'b1};

    bus0.s_data = '0; bus0.s_valid = 1'b0; bus0.s_last = 1'b0;
    bus1.s_data = '0; bus1.s_valid = 1'b0; bus1.s_last = 1'b0;

    // T1: reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t1_o_data0",    bus0.o_data,         '0);
    chk("t1_valid_out0", VW'(bus0.valid_out), VW'(0));
    chk("t1_frame_err0", VW'(bus0.frame_err), VW'(0));
    chk("t1_s_ready0",   VW'(bus0.s_ready),   VW'(1));
    chk("t1_o_data1",    bus1.o_data,         '0);
    chk("t1_valid_out1", VW'(bus1.valid_out), VW'(0));
    chk("t1_frame_err1", VW'(bus1.frame_err), VW'(0));
    chk("t1_s_ready1",   VW'(bus1.s_ready),   VW'(1));
    rst = 1'b1;
    @(negedge clk);
    #1;
    stab_en = 1'b1;

    // T2: one vector, exact latency and single-cycle s_ready drop
    p0 = pulses0;
    r0 = rdy_low0;
    for (int k = 0; k < NW; k++) send_word0(32'h3F80_0000 + 32'(k), k == NW - 1);
    chk("t2_ready_after_last", VW'(bus0.s_ready),   VW'(0));
    chk("t2_no_early_pulse",   VW'(bus0.valid_out), VW'(0));
    @(posedge clk);
    #1;
    chk("t2_pulse",            VW'(bus0.valid_out), VW'(1));
    chk("t2_o_data",           bus0.o_data,         mk_vec(32'h3F80_0000));
    chk("t2_ready_back",       VW'(bus0.s_ready),   VW'(1));
    @(posedge clk);
    #1;
    chk("t2_pulse_one_cycle",  VW'(bus0.valid_out), VW'(0));
    @(negedge clk);
    #1;
    chk("t2_pulse_count",      VW'(pulses0 - p0),   VW'(1));
    chk("t2_ready_low_cycles", VW'(rdy_low0 - r0),  VW'(1));
    cur_exp = mk_vec(32'h3F80_0000);

    // T3/T4 and boundary frames from the vector table
    for (int i = 0; i < 7; i++) begin
      p0 = pulses0;
      for (int k = 0; k < int'(vt[i].nwords); k++) begin
        if (vt[i].bubbles[k]) @(negedge clk);
        send_word0(vt[i].base + 32'(k), vt[i].last && (k == int'(vt[i].nwords) - 1));
      end
      repeat (3) @(negedge clk);
      #1;
      if (vt[i].exp_pulses != 0) cur_exp = mk_vec(vt[i].base);
      chk($sformatf("vec%0d_pulses", i),    VW'(pulses0 - p0),   VW'(vt[i].exp_pulses));
      chk($sformatf("vec%0d_o_data", i),    bus0.o_data,         cur_exp);
      chk($sformatf("vec%0d_frame_err", i), VW'(bus0.frame_err), VW'(vt[i].exp_err));
    end

    // T5: MIN_GAP=20, two frames back to back
    p0 = pulses0;
    p1 = pulses1;
    r1 = rdy_low1;
    for (int k = 0; k < 2 * NW; k++) begin
      send_word1(((k < NW) ? 32'h3E00_0000 : 32'h42C8_0000) + 32'(k % NW), (k % NW) == NW - 1);
    end
    repeat (8) @(negedge clk);
    #1;
    chk("t5_pulses",      VW'(pulses1 - p1),          VW'(2));
    chk("t5_spacing",     VW'(p1_cyc[1] - p1_cyc[0]), VW'(21));
    chk("t5_data_a",      p1_data[0],                 mk_vec(32'h3E00_0000));
    chk("t5_data_b",      p1_data[1],                 mk_vec(32'h42C8_0000));
    chk("t5_ready_low",   VW'(rdy_low1 - r1),         VW'(6));
    chk("t5_frame_err",   VW'(bus1.frame_err),        VW'(0));
    chk("t5_bus0_quiet",  VW'(pulses0 - p0),          VW'(0));

    // T6: reset mid-frame discards the partial vector
    for (int k = 0; k < 7; k++) send_word0(32'hDEAD_0000 + 32'(k), 1'b0);
    stab_en = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_o_data",    bus0.o_data,         '0);
    chk("t6_rst_valid_out", VW'(bus0.valid_out), VW'(0));
    chk("t6_rst_frame_err", VW'(bus0.frame_err), VW'(0));
    chk("t6_rst_s_ready",   VW'(bus0.s_ready),   VW'(1));
    rst = 1'b1;
    @(negedge clk);
    #1;
    stab_en = 1'b1;
    p0 = pulses0;
    for (int k = 0; k < NW; k++) send_word0(32'h0BAD_0000 + 32'(k), k == NW - 1);
    repeat (3) @(negedge clk);
    #1;
    chk("t6_pulses",    VW'(pulses0 - p0),   VW'(1));
    chk("t6_data",      last_data0,          mk_vec(32'h0BAD_0000));
    chk("t6_frame_err", VW'(bus0.frame_err), VW'(0));

    chk("o_data_stability", VW'(stab_err), VW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
